// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the data-RAM arbiter.
`include "defines.sv"

package ram_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_M0   = 2'd1,
        ARB_M1   = 2'd2
    } arb_state_e;

    // Size 2'b11 is treated by the RAM as a word store but is never rejected here.
    function automatic logic access_ok(
        input logic [1:0] size,
        input logic [1:0] addr
    );
        case (size)
            `SW:     return addr == 2'b00;
            `SH:     return !addr[0];
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/defines.sv
// Store-size encodings shared by the core, the RAM and the RAM arbiter.
`ifndef DEFINES_SV
`define DEFINES_SV
`define SB 2'b00
`define SH 2'b01
`define SW 2'b10
`endif

// File: rtl/ram_arbiter_rr_grant.sv
// Two-way round-robin grant picker with a per-owner burst limit.
module rr_grant
    import ram_arb_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int CW        = 3
) (
    input  logic          req0,
    input  logic          req1,
    input  logic          last_owner,
    input  arb_state_e    state,
    input  logic [CW-1:0] burst_cnt,
    output logic          gnt0,
    output logic          gnt1
);

    localparam logic [CW-1:0] LIMIT = CW'(MAX_BURST);

    logic keep;
    logic pick0;

    always_comb begin
        keep  = burst_cnt < LIMIT;
        pick0 = 1'b0;
        case (state)
            ARB_M0:  pick0 = keep;
            ARB_M1:  pick0 = !keep;
            default: pick0 = last_owner;
        endcase
        gnt0 = req0 & (!req1 | pick0);
        gnt1 = req1 & (!req0 | !pick0);
    end

endmodule

// File: rtl/ram_arbiter.sv
// Data-RAM arbiter between the LSU (m0) and the loader/debug master (m1).
// Optional address range check: define RAM_ARB_RANGE_CHECK_EN.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_WORDS = 10,
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [1:0]  m0_size,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [1:0]  m1_size,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        ram_we,
    output logic [1:0]  ram_store_size,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] LIMIT = CW'(MAX_BURST);

    arb_state_e    state;
    logic          last_owner;
    logic [CW-1:0] burst_cnt;
    logic [CW-1:0] cnt_inc;
    logic          ok0;
    logic          ok1;
    logic          ld0;
    logic          ld1;

    always_comb begin
        ok0 = access_ok(m0_size, m0_addr[1:0]);
        ok1 = access_ok(m1_size, m1_addr[1:0]);
`ifdef RAM_ARB_RANGE_CHECK_EN
        ok0 = ok0 & (m0_addr[31:2] < 30'(NUM_WORDS));
        ok1 = ok1 & (m1_addr[31:2] < 30'(NUM_WORDS));
`endif
    end

`ifndef RAM_ARB_RANGE_CHECK_EN
    localparam int unused_num_words = NUM_WORDS;
`endif

    // No grants while reset is held so the RAM sees no write.
    rr_grant #(
        .MAX_BURST (MAX_BURST),
        .CW        (CW)
    ) u_grant (
        .req0       (m0_req & reset_n),
        .req1       (m1_req & reset_n),
        .last_owner (last_owner),
        .state      (state),
        .burst_cnt  (burst_cnt),
        .gnt0       (m0_gnt),
        .gnt1       (m1_gnt)
    );

    assign ram_addr       = m1_gnt ? m1_addr : m0_addr;
    assign ram_wdata      = m1_gnt ? m1_wdata : m0_wdata;
    assign ram_store_size = m1_gnt ? m1_size : m0_size;
    assign ram_we         = m1_gnt ? (m1_we & ok1) : (m0_gnt & m0_we & ok0);

    assign ld0     = m0_gnt & !m0_we & ok0;
    assign ld1     = m1_gnt & !m1_we & ok1;
    assign cnt_inc = (burst_cnt < LIMIT) ? burst_cnt + CW'(1) : burst_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ARB_IDLE;
            last_owner <= 1'b1;
            burst_cnt  <= '0;
            m0_rvalid  <= 1'b0;
            m0_err     <= 1'b0;
            m0_rdata   <= '0;
            m1_rvalid  <= 1'b0;
            m1_err     <= 1'b0;
            m1_rdata   <= '0;
        end else begin
            if (m0_gnt) begin
                state      <= ARB_M0;
                last_owner <= 1'b0;
                burst_cnt  <= (state == ARB_M0) ? cnt_inc : CW'(1);
            end else if (m1_gnt) begin
                state      <= ARB_M1;
                last_owner <= 1'b1;
                burst_cnt  <= (state == ARB_M1) ? cnt_inc : CW'(1);
            end else begin
                state     <= ARB_IDLE;
                burst_cnt <= '0;
            end
            m0_rvalid <= ld0;
            m0_err    <= m0_gnt & !ok0;
            m1_rvalid <= ld1;
            m1_err    <= m1_gnt & !ok1;
            if (ld0) m0_rdata <= ram_rdata;
            if (ld1) m1_rdata <= ram_rdata;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized and directed bench for ram_arbiter against a transaction-level model.
module tb_ram_arbiter;

    localparam int MAXB = 4;
    localparam int NW   = 10;
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    logic        clk;
    logic        reset_n;
    logic        rq [2];
    logic        wr [2];
    logic [1:0]  sz [2];
    logic [31:0] ad [2];
    logic [31:0] wd [2];

    logic        m0_gnt, m0_rvalid, m0_err;
    logic        m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        ram_we;
    logic [1:0]  ram_store_size;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;

    ram_arbiter #(.NUM_WORDS(NW), .MAX_BURST(MAXB)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .m0_req         (rq[0]),
        .m0_we          (wr[0]),
        .m0_size        (sz[0]),
        .m0_addr        (ad[0]),
        .m0_wdata       (wd[0]),
        .m0_gnt         (m0_gnt),
        .m0_rvalid      (m0_rvalid),
        .m0_rdata       (m0_rdata),
        .m0_err         (m0_err),
        .m1_req         (rq[1]),
        .m1_we          (wr[1]),
        .m1_size        (sz[1]),
        .m1_addr        (ad[1]),
        .m1_wdata       (wd[1]),
        .m1_gnt         (m1_gnt),
        .m1_rvalid      (m1_rvalid),
        .m1_rdata       (m1_rdata),
        .m1_err         (m1_err),
        .ram_we         (ram_we),
        .ram_store_size (ram_store_size),
        .ram_addr       (ram_addr),
        .ram_wdata      (ram_wdata),
        .ram_rdata      (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] merge(
        input logic [31:0] old,
        input logic [31:0] dat,
        input logic [1:0]  s,
        input logic [1:0]  a
    );
        logic [31:0] r;
        r = old;
        case (s)
            SZ_B:    r[int'(a) * 8 +: 8] = dat[7:0];
            SZ_H:    r[int'(a[1]) * 16 +: 16] = dat[15:0];
            default: r = dat;
        endcase
        return r;
    endfunction

    // Environment RAM: combinational read, write on the clock edge.
    logic [31:0] ram [16];
    assign ram_rdata = ram[ram_addr[5:2]];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) ram[i] <= '0;
        end else if (ram_we) begin
            ram[ram_addr[5:2]] <= merge(ram[ram_addr[5:2]], ram_wdata,
                                        ram_store_size, ram_addr[1:0]);
        end
    end

    // Reference model state.
    int          prev;
    int          run;
    int          last;
    int          last_g;
    logic [31:0] mmem [16];
    logic        e_rv [2];
    logic        e_err [2];
    logic [31:0] e_rd [2];
    int          n_vec;
    int          n_bad;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic ok_of(input logic [1:0] s, input logic [31:0] a);
        logic ok;
        ok = 1'b1;
        if (s == SZ_W && a[1:0] != 2'b00) ok = 1'b0;
        if (s == SZ_H && a[0]) ok = 1'b0;
`ifdef RAM_ARB_RANGE_CHECK_EN
        if (a[31:2] >= NW) ok = 1'b0;
`endif
        return ok;
    endfunction

    task automatic model_reset();
        prev = -1;
        run  = 0;
        last = 1;
        for (int i = 0; i < 16; i++) mmem[i] = '0;
        for (int m = 0; m < 2; m++) begin
            e_rv[m]  = 1'b0;
            e_err[m] = 1'b0;
            e_rd[m]  = '0;
        end
    endtask

    // One cycle: entered right after a falling edge with inputs driven.
    task automatic cycle();
        int   g;
        logic okg;
        #1;
        g = -1;
        if (rq[0] && rq[1]) begin
            if (prev < 0) g = 1 - last;
            else g = (run < MAXB) ? prev : 1 - prev;
        end else if (rq[0]) g = 0;
        else if (rq[1]) g = 1;
        last_g = g;

        chk("m0_gnt", m0_gnt, g == 0);
        chk("m1_gnt", m1_gnt, g == 1);
        chk("m0_rvalid", m0_rvalid, e_rv[0]);
        chk("m0_err", m0_err, e_err[0]);
        chk("m0_rdata", m0_rdata, e_rd[0]);
        chk("m1_rvalid", m1_rvalid, e_rv[1]);
        chk("m1_err", m1_err, e_err[1]);
        chk("m1_rdata", m1_rdata, e_rd[1]);

        okg = 1'b0;
        if (g >= 0) begin
            okg = ok_of(sz[g], ad[g]);
            chk("ram_addr", ram_addr, ad[g]);
            chk("ram_wdata", ram_wdata, wd[g]);
            chk("ram_size", ram_store_size, sz[g]);
            chk("ram_we", ram_we, wr[g] & okg);
        end else begin
            chk("ram_we_idle", ram_we, 1'b0);
        end

        for (int m = 0; m < 2; m++) begin
            e_rv[m]  = 1'b0;
            e_err[m] = 1'b0;
        end
        if (g >= 0) begin
            if (!okg) e_err[g] = 1'b1;
            else if (!wr[g]) begin
                e_rv[g] = 1'b1;
                e_rd[g] = mmem[ad[g][5:2]];
            end else begin
                mmem[ad[g][5:2]] = merge(mmem[ad[g][5:2]], wd[g],
                                         sz[g], ad[g][1:0]);
            end
            run  = (g == prev) ? run + 1 : 1;
            prev = g;
            last = g;
        end else begin
            run  = 0;
            prev = -1;
        end
        @(negedge clk);
    endtask

    task automatic drive(input int m, input logic w, input logic [1:0] s,
                         input logic [31:0] a, input logic [31:0] d);
        rq[m] = 1'b1;
        wr[m] = w;
        sz[m] = s;
        ad[m] = a;
        wd[m] = d;
    endtask

    initial begin
        n_vec   = 0;
        n_bad   = 0;
        last_g  = -1;
        reset_n = 1'b0;
        for (int m = 0; m < 2; m++) begin
            rq[m] = 1'b0;
            wr[m] = 1'b0;
            sz[m] = SZ_W;
            ad[m] = '0;
            wd[m] = '0;
        end
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rvalid", {m1_rvalid, m0_rvalid}, 2'b00);
        chk("rst_err", {m1_err, m0_err}, 2'b00);
        chk("rst_rdata0", m0_rdata, 32'h0);
        chk("rst_rdata1", m1_rdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Both at once after reset, then again after an idle cycle.
        drive(0, 1'b0, SZ_W, 32'h0, 32'h0);
        drive(1, 1'b0, SZ_W, 32'h4, 32'h0);
        cycle();
        rq[0] = 1'b0; rq[1] = 1'b0;
        cycle();
        rq[0] = 1'b1; rq[1] = 1'b1;
        cycle();
        rq[0] = 1'b0; rq[1] = 1'b0;
        cycle();

        // Word store then load back.
        drive(0, 1'b1, SZ_W, 32'h8, 32'h1234_5678);
        cycle();
        drive(0, 1'b0, SZ_W, 32'h8, 32'h0);
        cycle();
        rq[0] = 1'b0;
        cycle();

        // Misaligned halfword store from m1 must not touch the RAM.
        drive(1, 1'b1, SZ_H, 32'h3, 32'hFFFF_FFFF);
        cycle();
        rq[1] = 1'b0;
        drive(0, 1'b0, SZ_W, 32'h0, 32'h0);
        cycle();
        rq[0] = 1'b0;
        cycle();

        // Load from word index NUM_WORDS.
        drive(0, 1'b0, SZ_W, 32'h28, 32'h0);
        cycle();
        rq[0] = 1'b0;
        cycle();

        // Burst limit: m0 alone, then both requesting continuously.
        drive(0, 1'b0, SZ_W, 32'h8, 32'h0);
        cycle();
        drive(1, 1'b0, SZ_W, 32'hC, 32'h0);
        repeat (14) cycle();
        rq[0] = 1'b0; rq[1] = 1'b0;
        cycle();

        // Reset asserted after a load grant, before its capture edge.
        drive(0, 1'b0, SZ_W, 32'h8, 32'h0);
        #1;
        chk("pre_rst_gnt", m0_gnt, 1'b1);
        #1;
        reset_n = 1'b0;
        rq[0]   = 1'b0;
        #1;
        chk("rst_gnt", {m1_gnt, m0_gnt}, 2'b00);
        chk("rst_we", ram_we, 1'b0);
        chk("rst_rv_now", {m1_rvalid, m0_rvalid}, 2'b00);
        chk("rst_err_now", {m1_err, m0_err}, 2'b00);
        chk("rst_rd_now", m0_rdata, 32'h0);
        @(posedge clk);
        #1;
        chk("rst_rv_after", m0_rvalid, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();

        // Random traffic; a request stays up until it is granted.
        for (int n = 0; n < 400; n++) begin
            for (int m = 0; m < 2; m++) begin
                if (!rq[m] && ($urandom % 4) != 0) begin
                    drive(m, 1'($urandom % 2), 2'($urandom % 4),
                          32'($urandom % 64), $urandom);
                end
            end
            cycle();
            if (last_g >= 0) rq[last_g] = 1'b0;
        end
        rq[0] = 1'b0; rq[1] = 1'b0;
        cycle();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
